// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle of the branch resolve unit: a valid/ready request
// channel and a valid/ready result channel sharing one clock.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [2:0]      func210;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;

    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic            mispredict;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] link;

    modport master (
        output in_valid, op, func210, rs1, rs2, pc, imm, pred_taken, out_ready,
        input  in_ready, out_valid, taken, mispredict, illegal, target, redirect_pc, link
    );

    modport slave (
        input  in_valid, op, func210, rs1, rs2, pc, imm, pred_taken, out_ready,
        output in_ready, out_valid, taken, mispredict, illegal, target, redirect_pc, link
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches, jal and jalr one request per cycle into a
// registered result slot, and keeps saturating branch statistics.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    branch_resolve_unit_if.slave bus,
    output logic [CNT_W-1:0]     br_cnt,
    output logic [CNT_W-1:0]     taken_cnt,
    output logic [CNT_W-1:0]     mispred_cnt
);
    localparam logic [XLEN-1:0]  LINK_STEP = XLEN'(32'd4);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(32'd1));
    localparam logic [XLEN-1:0]  XLEN_ZERO = {XLEN{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic cond_taken(input logic [2:0] code,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        logic res;
        case (code)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = ($signed(a) <  $signed(b));
            3'b101:  res = ($signed(a) >= $signed(b));
            3'b110:  res = (a <  b);
            3'b111:  res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic cond_legal(input logic [2:0] code);
        return !((code == 3'b010) || (code == 3'b011));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic en);
        logic [CNT_W-1:0] res;
        if (en && (value != CNT_MAX)) begin
            res = value + CNT_ONE;
        end else begin
            res = value;
        end
        return res;
    endfunction

    logic            in_ready_s;
    logic            accept_s;
    logic            taken_s;
    logic            mispredict_s;
    logic            illegal_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] link_s;
    logic [XLEN-1:0] redirect_s;

    logic             out_valid_r;
    logic             taken_r;
    logic             mispredict_r;
    logic             illegal_r;
    logic [XLEN-1:0]  target_r;
    logic [XLEN-1:0]  redirect_r;
    logic [XLEN-1:0]  link_r;
    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;
    logic [CNT_W-1:0] mispred_cnt_r;

    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Combinational resolution of the request currently on the bus.
    always_comb begin
        taken_s      = 1'b0;
        mispredict_s = 1'b0;
        illegal_s    = 1'b0;
        target_s     = bus.pc + bus.imm;
        link_s       = bus.pc + LINK_STEP;
        case (bus.op)
            2'b00: begin
                if (cond_legal(bus.func210)) begin
                    taken_s      = cond_taken(bus.func210, bus.rs1, bus.rs2);
                    mispredict_s = (taken_s != bus.pred_taken);
                end else begin
                    illegal_s = 1'b1;
                end
            end
            2'b01: begin
                taken_s      = 1'b1;
                mispredict_s = !bus.pred_taken;
            end
            2'b10: begin
                // No target prediction exists for jalr, so it always redirects.
                target_s     = (bus.rs1 + bus.imm) & ALIGN_MASK;
                taken_s      = 1'b1;
                mispredict_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        if (taken_s) begin
            redirect_s = target_s;
        end else begin
            redirect_s = link_s;
        end
    end

    // Result slot: flush wins over a load, a load wins over a plain consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            taken_r      <= 1'b0;
            mispredict_r <= 1'b0;
            illegal_r    <= 1'b0;
            target_r     <= XLEN_ZERO;
            redirect_r   <= XLEN_ZERO;
            link_r       <= XLEN_ZERO;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            taken_r      <= taken_s;
            mispredict_r <= mispredict_s;
            illegal_r    <= illegal_s;
            target_r     <= target_s;
            redirect_r   <= redirect_s;
            link_r       <= link_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Statistics count every accepted legal request, even one dropped by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_r      <= CNT_ZERO;
            taken_cnt_r   <= CNT_ZERO;
            mispred_cnt_r <= CNT_ZERO;
        end else if (accept_s && !illegal_s) begin
            br_cnt_r      <= sat_inc(br_cnt_r, 1'b1);
            taken_cnt_r   <= sat_inc(taken_cnt_r, taken_s);
            mispred_cnt_r <= sat_inc(mispred_cnt_r, mispredict_s);
        end else begin
            br_cnt_r      <= br_cnt_r;
            taken_cnt_r   <= taken_cnt_r;
            mispred_cnt_r <= mispred_cnt_r;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.taken       = taken_r;
    assign bus.mispredict  = mispredict_r;
    assign bus.illegal     = illegal_r;
    assign bus.target      = target_r;
    assign bus.redirect_pc = redirect_r;
    assign bus.link        = link_r;
    assign br_cnt          = br_cnt_r;
    assign taken_cnt       = taken_cnt_r;
    assign mispred_cnt     = mispred_cnt_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a transaction-level reference model; a CNT_W=2 copy covers saturation.
module tb_branch_resolve_unit;
    localparam int XLEN = 32;
    localparam int CMAX = 65535;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] target;
        logic [31:0] redirect;
        logic [31:0] link;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, rst2, flush2;
    logic [15:0] br_cnt, taken_cnt, mispred_cnt;
    logic [1:0]  br2, tk2, mp2;

    branch_resolve_unit_if #(.XLEN(XLEN)) bus ();
    branch_resolve_unit_if #(.XLEN(XLEN)) bus2 ();

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .flush(flush2), .bus(bus2.slave),
        .br_cnt(br2), .taken_cnt(tk2), .mispred_cnt(mp2)
    );

    int   err_cnt = 0;
    int   chk_cnt = 0;

    // reference model state
    logic m_valid, m_known, m_tgt;
    res_t m_res;
    int   m_br, m_tk, m_mp;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] op, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pred);
        res_t r;
        r = '0;
        r.link   = pc + 32'd4;
        r.target = (op == 2'b10) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        if (op == 2'b00) begin
            case (f)
                3'd0: r.taken = (a == b);
                3'd1: r.taken = (a != b);
                3'd4: r.taken = ($signed(a) < $signed(b));
                3'd5: r.taken = !($signed(a) < $signed(b));
                3'd6: r.taken = (a < b);
                3'd7: r.taken = !(a < b);
                default: r.ill = 1'b1;
            endcase
        end else if (op == 2'b11) begin
            r.ill = 1'b1;
        end else begin
            r.taken = 1'b1;
        end
        if (r.ill) r.mis = 1'b0;
        else if (op == 2'b10) r.mis = 1'b1;
        else r.mis = (r.taken != pred);
        r.redirect = r.taken ? r.target : r.link;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic rdy);
        bus.in_valid = v; bus.op = op; bus.func210 = f; bus.rs1 = a; bus.rs2 = b;
        bus.pc = pc; bus.imm = imm; bus.pred_taken = pred; bus.out_ready = rdy;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then compare.
    task automatic tick();
        res_t r;
        logic acc;
        r   = model(bus.op, bus.func210, bus.rs1, bus.rs2, bus.pc, bus.imm, bus.pred_taken);
        acc = bus.in_valid && (!m_valid || bus.out_ready);
        if (rst) begin
            m_valid = 1'b0; m_known = 1'b1; m_tgt = 1'b1; m_res = '0;
            m_br = 0; m_tk = 0; m_mp = 0;
        end else begin
            if (acc && !r.ill) begin
                if (m_br < CMAX) m_br++;
                if (r.taken && m_tk < CMAX) m_tk++;
                if (r.mis && m_mp < CMAX) m_mp++;
            end
            if (flush) begin
                m_valid = 1'b0; m_known = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1; m_known = 1'b1; m_res = r; m_tgt = (bus.op != 2'b11);
            end else if (bus.out_ready) begin
                m_valid = 1'b0; m_known = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid, m_valid);
        chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
        if (m_known) begin
            chk("taken", bus.taken, m_res.taken);
            chk("mispredict", bus.mispredict, m_res.mis);
            chk("illegal", bus.illegal, m_res.ill);
            chk("redirect_pc", bus.redirect_pc, m_res.redirect);
            chk("link", bus.link, m_res.link);
            if (m_tgt) chk("target", bus.target, m_res.target);
        end
        chk("br_cnt", br_cnt, m_br);
        chk("taken_cnt", taken_cnt, m_tk);
        chk("mispred_cnt", mispred_cnt, m_mp);
    endtask

    initial begin
        logic [15:0] br_before;
        logic [31:0] ra, rb;
        m_valid = 1'b0; m_known = 1'b0; m_tgt = 1'b0; m_res = '0;
        m_br = 0; m_tk = 0; m_mp = 0;
        rst = 1'b1; flush = 1'b0; rst2 = 1'b1; flush2 = 1'b0;
        bus2.in_valid = 1'b0; bus2.op = 2'b01; bus2.func210 = 3'd0; bus2.rs1 = 32'd0;
        bus2.rs2 = 32'd0; bus2.pc = 32'h40; bus2.imm = 32'h8; bus2.pred_taken = 1'b1;
        bus2.out_ready = 1'b1;
        drive(1'b1, 2'b01, 3'd0, 32'd5, 32'd6, 32'h200, 32'h10, 1'b0, 1'b1);
        #1;
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        chk("ready_after_reset", bus.in_ready, 1'b1);

        // Scenario 1: signed compare of -1 < 1 taken against a not-taken prediction
        drive(1'b1, 2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b1);
        tick();
        chk("s1_taken", bus.taken, 1'b1);
        chk("s1_target", bus.target, 32'h120);
        chk("s1_redirect", bus.redirect_pc, 32'h120);
        chk("s1_link", bus.link, 32'h104);
        chk("s1_br_cnt", br_cnt, 16'd1);
        chk("s1_mispred_cnt", mispred_cnt, 16'd1);
        // Scenario 2: unsigned compare of same operands is not taken
        bus.func210 = 3'b110;
        tick();
        chk("s2_taken", bus.taken, 1'b0);
        chk("s2_mispredict", bus.mispredict, 1'b0);
        chk("s2_redirect", bus.redirect_pc, 32'h104);
        // Scenario 3: jalr clears bit 0
        drive(1'b1, 2'b10, 3'd0, 32'h1003, 32'd0, 32'h300, 32'd0, 1'b1, 1'b1);
        tick();
        chk("s3_target", bus.target, 32'h1002);
        chk("s3_mispredict", bus.mispredict, 1'b1);
        // Scenario 4: stall three cycles with a pending request, then release
        drive(1'b1, 2'b00, 3'b000, 32'd9, 32'd9, 32'h500, 32'h40, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_stall_ready", bus.in_ready, 1'b0);
            chk("s4_hold_target", bus.target, 32'h1002);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("s4_new_valid", bus.out_valid, 1'b1);
        chk("s4_new_target", bus.target, 32'h540);
        // Scenario 5: flush drops an accepted request but it is still counted
        br_before = br_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s5_valid", bus.out_valid, 1'b0);
        chk("s5_br_cnt", br_cnt, br_before + 16'd1);
        // Scenario 6 on the CNT_W=2 copy; main unit idles
        drive(1'b0, 2'b00, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        rst2 = 1'b0;
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("s6_br_sat", br2, 2'd3);
        chk("s6_taken_sat", tk2, 2'd3);
        bus2.op = 2'b00; bus2.func210 = 3'b011;
        tick();
        chk("s6_illegal", bus2.illegal, 1'b1);
        chk("s6_ill_taken", bus2.taken, 1'b0);
        chk("s6_ill_redirect", bus2.redirect_pc, 32'h44);
        chk("s6_br_kept", br2, 2'd3);
        rst2 = 1'b1;
        tick();
        chk("s6_rst_valid", bus2.out_valid, 1'b0);
        chk("s6_rst_flags", {bus2.taken, bus2.mispredict, bus2.illegal}, 3'b000);
        chk("s6_rst_target", bus2.target, 32'd0);
        chk("s6_rst_redirect", bus2.redirect_pc, 32'd0);
        chk("s6_rst_link", bus2.link, 32'd0);
        chk("s6_rst_cnts", {br2, tk2, mp2}, 6'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ra, rb, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
